// File: rtl/mem_check_pkg.sv
// Shared types, mode encodings and LFSR helper for the memory read checker.
package mem_check_pkg;

    typedef enum logic {
        IDLE_S,
        RUN_S
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_LFSR  = 1'b1;

    // An all-zero LFSR would never leave zero, so a zero seed is replaced.
    localparam logic [7:0] LFSR_LOCKUP_FIX = 8'hFF;

    function automatic logic [7:0] lfsr_next(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

endpackage

// File: rtl/mem_rd_checker_if.sv
// Read command and read data bus between the Avalon-MM master and the checker.
interface mem_rd_checker_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BURST_W = 4
);
    logic               cmd_valid_i;
    logic [ADDR_W-1:0]  cmd_addr_i;
    logic [BURST_W-1:0] cmd_burstcount_i;
    logic               cmd_ready_o;
    logic               readdatavalid_i;
    logic [DATA_W-1:0]  readdata_i;

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_burstcount_i, readdatavalid_i, readdata_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_burstcount_i, readdatavalid_i, readdata_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/rd_addr_fifo.sv
// Synchronous FIFO holding {start address, burstcount} of outstanding reads.
module rd_addr_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q[PTR_W-1:0]];

    // Pointer next-state: flush wins over push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_ONE;
            if (do_pop)  rd_d = rd_q + PTR_ONE;
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q[PTR_W-1:0]] <= din_i;
    end
endmodule

// File: rtl/mem_rd_checker.sv
// Checks read data from the memory under test against a regenerated pattern,
// logging mismatch count and the first failing address/data.
module mem_rd_checker
    import mem_check_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BURST_W    = 4,
    parameter int unsigned CSR_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               data_mode_i,
    input  logic [7:0]         pattern_i,
    input  logic [CSR_W-1:0]   words_total_i,
    mem_rd_checker_if.slave    rd_if,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_flag_o,
    output logic [CSR_W-1:0]   err_cnt_o,
    output logic [ADDR_W-1:0]  err_addr_o,
    output logic [DATA_W-1:0]  err_data_o
);
    localparam int unsigned FW = ADDR_W + BURST_W;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [7:0]         byte_q, byte_d;
    logic [CSR_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] offset_q, offset_d;
    logic               chk_valid_q, chk_valid_d;
    logic               chk_mis_q, chk_mis_d;
    logic [ADDR_W-1:0]  chk_addr_q, chk_addr_d;
    logic [DATA_W-1:0]  chk_data_q, chk_data_d;
    logic               err_flag_q, err_flag_d;
    logic [CSR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
    logic [DATA_W-1:0]  err_data_q, err_data_d;
    logic               done_q, done_d;

    logic               fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic [FW-1:0]      fifo_head;
    logic [ADDR_W-1:0]  head_addr, word_addr;
    logic [BURST_W-1:0] head_burst;
    logic               accept, last_in_burst;
    logic [DATA_W-1:0]  exp_word;

    assign head_addr     = fifo_head[FW-1:BURST_W];
    assign head_burst    = fifo_head[BURST_W-1:0];
    assign accept        = (state_q == RUN_S) && rd_if.readdatavalid_i && (cnt_q != words_total_i);
    assign last_in_burst = (offset_q == head_burst - BURST_W'(1));
    assign word_addr     = fifo_empty ? '1 : head_addr + ADDR_W'(offset_q);
    assign exp_word      = {(DATA_W/8){byte_q}};
    assign fifo_pop      = accept && !fifo_empty && last_in_burst;
    assign fifo_push     = (state_q == RUN_S) && rd_if.cmd_valid_i && (rd_if.cmd_burstcount_i != '0);
    assign fifo_flush    = (state_q == IDLE_S) && start_i;

    rd_addr_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .din_i   ({rd_if.cmd_addr_i, rd_if.cmd_burstcount_i}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rd_if.cmd_ready_o = !fifo_full;
    assign busy_o            = (state_q == RUN_S);
    assign done_o            = done_q;
    assign err_flag_o        = err_flag_q;
    assign err_cnt_o         = err_cnt_q;
    assign err_addr_o        = err_addr_q;
    assign err_data_o        = err_data_q;

    // FSM and datapath next-state: word accept/compare stage, then error logging.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        offset_d    = offset_q;
        chk_valid_d = 1'b0;
        chk_mis_d   = chk_mis_q;
        chk_addr_d  = chk_addr_q;
        chk_data_d  = chk_data_q;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        err_addr_d  = err_addr_q;
        err_data_d  = err_data_q;
        done_d      = 1'b0;

        // Result of the word registered on the previous edge.
        if (chk_valid_q && chk_mis_q) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CSR_W'(1);
            if (!err_flag_q) begin
                err_addr_d = chk_addr_q;
                err_data_d = chk_data_q;
            end
        end

        case (state_q)
            IDLE_S: begin
                if (start_i) begin
                    state_d    = RUN_S;
                    mode_d     = data_mode_i;
                    byte_d     = (data_mode_i == MODE_LFSR && pattern_i == 8'h00) ?
                                 LFSR_LOCKUP_FIX : pattern_i;
                    cnt_d      = '0;
                    offset_d   = '0;
                    err_flag_d = 1'b0;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    err_data_d = '0;
                end
            end
            RUN_S: begin
                if (accept) begin
                    cnt_d       = cnt_q + CSR_W'(1);
                    chk_valid_d = 1'b1;
                    chk_mis_d   = fifo_empty || (rd_if.readdata_i != exp_word);
                    chk_addr_d  = word_addr;
                    chk_data_d  = rd_if.readdata_i;
                    if (mode_q == MODE_LFSR) byte_d = lfsr_next(byte_q);
                    if (!fifo_empty) offset_d = last_in_burst ? '0 : offset_q + BURST_W'(1);
                end
                // The last word was accepted on the previous edge, so its
                // compare result lands on this same edge as done.
                if (cnt_q == words_total_i) begin
                    state_d = IDLE_S;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE_S;
            mode_q      <= 1'b0;
            byte_q      <= '0;
            cnt_q       <= '0;
            offset_q    <= '0;
            chk_valid_q <= 1'b0;
            chk_mis_q   <= 1'b0;
            chk_addr_q  <= '0;
            chk_data_q  <= '0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
            offset_q    <= offset_d;
            chk_valid_q <= chk_valid_d;
            chk_mis_q   <= chk_mis_d;
            chk_addr_q  <= chk_addr_d;
            chk_data_q  <= chk_data_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            err_data_q  <= err_data_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_mem_rd_checker.sv
// Self-checking bench for mem_rd_checker: directed scenarios plus randomized
// runs against a queue-based reference model.
module tb_mem_rd_checker;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BURST_W    = 4;
    localparam int unsigned CSR_W      = 16;
    localparam int unsigned FIFO_DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               mode = 1'b0;
    logic [7:0]         pattern = '0;
    logic [CSR_W-1:0]   total = '0;
    logic               busy, done, err_flag;
    logic [CSR_W-1:0]   err_cnt;
    logic [ADDR_W-1:0]  err_addr;
    logic [DATA_W-1:0]  err_data;

    int checks = 0;
    int failures = 0;

    mem_rd_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) rd_if();

    mem_rd_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
        .CSR_W(CSR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data_mode_i(mode),
        .pattern_i(pattern), .words_total_i(total), .rd_if(rd_if.slave),
        .busy_o(busy), .done_o(done), .err_flag_o(err_flag), .err_cnt_o(err_cnt),
        .err_addr_o(err_addr), .err_data_o(err_data)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Taps at bits 7,5,4,3 expressed as a parity mask.
    function automatic logic [7:0] model_lfsr(input logic [7:0] b);
        return {b[6:0], ^(b & 8'hB8)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        rd_if.cmd_valid_i      = 1'b0;
        rd_if.cmd_addr_i       = '0;
        rd_if.cmd_burstcount_i = '0;
        rd_if.readdatavalid_i  = 1'b0;
        rd_if.readdata_i       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0;
        idle_bus();
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic start_test(input logic m, input logic [7:0] p, input logic [CSR_W-1:0] t);
        mode = m; pattern = p; total = t; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_cmd(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] b);
        rd_if.cmd_valid_i = 1'b1; rd_if.cmd_addr_i = a; rd_if.cmd_burstcount_i = b;
        tick();
        rd_if.cmd_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d);
        rd_if.readdatavalid_i = 1'b1; rd_if.readdata_i = d;
        tick();
        rd_if.readdatavalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle_bus();
        tick();
        checks++;
        if ({busy, done, err_flag, rd_if.cmd_ready_o} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_ctrl: got busy/done/flag/ready=%b want 0001", {busy, done, err_flag, rd_if.cmd_ready_o});
        end
        checks++;
        if ({err_cnt, err_addr, err_data} !== '0) begin
            failures++;
            $display("FAIL reset_err: got cnt=%h addr=%h data=%h want all 0", err_cnt, err_addr, err_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_lfsr_burst();
        do_reset();
        start_test(1'b1, 8'hFF, 16'd4);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL lfsr_busy_after_start: got %b want 1", busy); end
        push_cmd(16'h0010, 4'd4);
        send_word(32'hFFFFFFFF); send_word(32'hFEFEFEFE);
        send_word(32'hFCFCFCFC); send_word(32'hF8F8F8F8);
        checks++;
        if ({done, busy} !== 2'b01) begin failures++; $display("FAIL lfsr_done_early: got done/busy=%b want 01", {done, busy}); end
        tick();
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL lfsr_done: got done/busy=%b want 10", {done, busy}); end
        checks++;
        if ({err_flag, err_cnt} !== '0) begin failures++; $display("FAIL lfsr_errs: got flag=%b cnt=%0d want 0 0", err_flag, err_cnt); end
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL lfsr_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_fixed_err();
        do_reset();
        start_test(1'b0, 8'hA5, 16'd3);
        push_cmd(16'h0100, 4'd3);
        send_word(32'hA5A5A5A5); send_word(32'hA5A5A5A5); send_word(32'hA5A5A500);
        tick();
        checks++;
        if ({done, err_flag, err_cnt} !== {1'b1, 1'b1, 16'd1}) begin
            failures++; $display("FAIL fixed_cnt: got done=%b flag=%b cnt=%0d want 1 1 1", done, err_flag, err_cnt);
        end
        checks++;
        if ({err_addr, err_data} !== {16'h0102, 32'hA5A5A500}) begin
            failures++; $display("FAIL fixed_first: got addr=%h data=%h want 0102 a5a5a500", err_addr, err_data);
        end
        // Data in IDLE is ignored and results hold.
        send_word(32'h00000000);
        tick();
        checks++;
        if ({busy, err_cnt, err_addr} !== {1'b0, 16'd1, 16'h0102}) begin
            failures++; $display("FAIL fixed_hold: got busy=%b cnt=%0d addr=%h want 0 1 0102", busy, err_cnt, err_addr);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        start_test(1'b0, 8'h3C, 16'd8);
        for (int i = 0; i < 8; i++) push_cmd(16'(i), 4'd1);
        checks++;
        if (rd_if.cmd_ready_o !== 1'b0) begin failures++; $display("FAIL fifo_full: got ready=%b want 0", rd_if.cmd_ready_o); end
        send_word(32'h3C3C3C3C);
        checks++;
        if (rd_if.cmd_ready_o !== 1'b1) begin failures++; $display("FAIL fifo_pop_ready: got ready=%b want 1", rd_if.cmd_ready_o); end
    endtask

    task automatic test_spurious();
        logic [DATA_W-1:0] d;
        d = $urandom;
        do_reset();
        start_test(1'b1, 8'h5A, 16'd1);
        send_word(d);
        tick();
        checks++;
        if ({done, err_flag, err_cnt, err_addr} !== {1'b1, 1'b1, 16'd1, 16'hFFFF}) begin
            failures++; $display("FAIL spurious: got done=%b flag=%b cnt=%0d addr=%h want 1 1 1 ffff", done, err_flag, err_cnt, err_addr);
        end
        checks++;
        if (err_data !== d) begin failures++; $display("FAIL spurious_data: got %h want %h", err_data, d); end
    endtask

    task automatic test_seed_zero();
        do_reset();
        start_test(1'b1, 8'h00, 16'd2);
        push_cmd(16'h0020, 4'd2);
        send_word(32'hFFFFFFFF); send_word(32'hFEFEFEFE);
        tick();
        checks++;
        if ({done, err_flag, err_cnt} !== {1'b1, 1'b0, 16'd0}) begin
            failures++; $display("FAIL seed_zero: got done=%b flag=%b cnt=%0d want 1 0 0", done, err_flag, err_cnt);
        end
    endtask

    task automatic test_words_zero();
        do_reset();
        start_test(1'b0, 8'h12, 16'd0);
        checks++;
        if ({busy, done} !== 2'b10) begin failures++; $display("FAIL zero_start: got busy/done=%b want 10", {busy, done}); end
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin failures++; $display("FAIL zero_done: got busy/done=%b want 01", {busy, done}); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        start_test(1'b0, 8'h11, 16'd5);
        push_cmd(16'h0040, 4'd2); push_cmd(16'h0050, 4'd2);
        send_word(32'hDEADBEEF);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({busy, done, err_flag, err_cnt, rd_if.cmd_ready_o} !== {3'b000, 16'd0, 1'b1}) begin
            failures++; $display("FAIL midrun_reset: got busy=%b done=%b flag=%b cnt=%0d ready=%b want 0 0 0 0 1",
                busy, done, err_flag, err_cnt, rd_if.cmd_ready_o);
        end
        send_word(32'hDEADBEEF);
        tick();
        checks++;
        if ({busy, err_cnt} !== {1'b0, 16'd0}) begin
            failures++; $display("FAIL midrun_ignore: got busy=%b cnt=%0d want 0 0", busy, err_cnt);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        bit                last;
    } word_t;

    task automatic test_random();
        for (int iter = 0; iter < 10; iter++) begin
            word_t             wq[$];
            int                entries, cmds_left, words_left, m_errs, guard;
            bit                m_flag, do_push, do_word;
            logic              m;
            logic [7:0]        p, exp_b;
            logic [ADDR_W-1:0] m_addr, ca;
            logic [DATA_W-1:0] m_data, d;
            logic [BURST_W-1:0] cb;
            int                bursts[$];
            int                sum;
            word_t             w;

            m = 1'($urandom_range(0, 1));
            p = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cmds_left = $urandom_range(1, 12);
            sum = 0;
            for (int i = 0; i < cmds_left; i++) begin
                bursts.push_back($urandom_range(1, 15));
                sum += bursts[i];
            end
            exp_b = (m && p == 8'h00) ? 8'hFF : p;
            entries = 0; words_left = sum; m_errs = 0; m_flag = 0;
            m_addr = '0; m_data = '0; guard = 0;
            start_test(m, p, 16'(sum));
            while (words_left > 0 && guard < 5000) begin
                guard++;
                do_push = (cmds_left > 0) && (entries < FIFO_DEPTH) && ($urandom_range(0, 1) == 1);
                do_word = (wq.size() > 0) && ($urandom_range(0, 2) != 0);
                checks++;
                if (rd_if.cmd_ready_o !== (entries < FIFO_DEPTH)) begin
                    failures++; $display("FAIL rand_ready: iter=%0d got %b want %b", iter, rd_if.cmd_ready_o, entries < FIFO_DEPTH);
                end
                ca = (iter % 3 == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
                cb = 4'(bursts[0]);
                if (do_push) begin
                    rd_if.cmd_valid_i = 1'b1; rd_if.cmd_addr_i = ca; rd_if.cmd_burstcount_i = cb;
                end
                if (do_word) begin
                    w = wq.pop_front();
                    d = {4{exp_b}};
                    if ($urandom_range(0, 4) == 0) d = d ^ (32'h1 << $urandom_range(0, 31));
                    if (d != {4{exp_b}}) begin
                        m_errs++;
                        if (!m_flag) begin m_addr = w.addr; m_data = d; end
                        m_flag = 1;
                    end
                    if (w.last) entries--;
                    if (m) exp_b = model_lfsr(exp_b);
                    words_left--;
                    rd_if.readdatavalid_i = 1'b1; rd_if.readdata_i = d;
                end
                tick();
                idle_bus();
                if (do_push) begin
                    for (int k = 0; k < int'(cb); k++) begin
                        w.addr = ca + 16'(k);
                        w.last = (k == int'(cb) - 1);
                        wq.push_back(w);
                    end
                    void'(bursts.pop_front());
                    entries++; cmds_left--;
                end
            end
            tick();
            checks++;
            if ({done, busy} !== 2'b10) begin
                failures++; $display("FAIL rand_done: iter=%0d got done/busy=%b want 10", iter, {done, busy});
            end
            checks++;
            if ({err_flag, err_cnt} !== {m_flag, 16'(m_errs)}) begin
                failures++; $display("FAIL rand_errs: iter=%0d got flag=%b cnt=%0d want %b %0d", iter, err_flag, err_cnt, m_flag, m_errs);
            end
            if (m_flag) begin
                checks++;
                if ({err_addr, err_data} !== {m_addr, m_data}) begin
                    failures++; $display("FAIL rand_first: iter=%0d got addr=%h data=%h want %h %h", iter, err_addr, err_data, m_addr, m_data);
                end
            end
            tick();
        end
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_lfsr_burst();
        test_fixed_err();
        test_fifo_full();
        test_spurious();
        test_seed_zero();
        test_words_zero();
        test_reset_midrun();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
